// File: rtl/mig_app_arbiter_if.sv
// MIG 7-series user (app) port: command, write-data and read-return channels.
// The arbiter is the master; the MIG core (or a bench model of it) is the slave.
interface mig_app_arbiter_if #(
   parameter int APP_ADDR_WIDTH = 29,
   parameter int APP_DATA_WIDTH = 256,
   parameter int APP_MASK_WIDTH = 32
);
   logic                      app_en;
   logic [2:0]                app_cmd;
   logic [APP_ADDR_WIDTH-1:0] app_addr;
   logic [APP_DATA_WIDTH-1:0] app_wdf_data;
   logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
   logic                      app_wdf_wren;
   logic                      app_wdf_end;
   logic                      app_rdy;
   logic                      app_wdf_rdy;
   logic [APP_DATA_WIDTH-1:0] app_rd_data;
   logic                      app_rd_data_valid;

   modport master (
      output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask,
             app_wdf_wren, app_wdf_end,
      input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );

   modport slave (
      input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask,
             app_wdf_wren, app_wdf_end,
      output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );
endinterface

// File: rtl/mig_app_arbiter.sv
// Two-client round-robin arbiter for the MIG 7-series app port. An in-order
// tag FIFO of client ids steers each returning read beat to its issuer.
module mig_app_arbiter #(
   parameter int APP_ADDR_WIDTH = 29,
   parameter int APP_DATA_WIDTH = 256,
   parameter int APP_MASK_WIDTH = 32,
   parameter int RD_FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          calib_done,
   input  logic                          c0_req,
   input  logic [2:0]                    c0_cmd,
   input  logic [APP_ADDR_WIDTH-1:0]     c0_addr,
   input  logic [APP_DATA_WIDTH-1:0]     c0_wdata,
   input  logic [APP_MASK_WIDTH-1:0]     c0_wmask,
   input  logic                          c1_req,
   input  logic [2:0]                    c1_cmd,
   input  logic [APP_ADDR_WIDTH-1:0]     c1_addr,
   input  logic [APP_DATA_WIDTH-1:0]     c1_wdata,
   input  logic [APP_MASK_WIDTH-1:0]     c1_wmask,
   output logic                          c0_gnt,
   output logic                          c1_gnt,
   output logic                          c0_rvalid,
   output logic                          c1_rvalid,
   output logic [APP_DATA_WIDTH-1:0]     rdata,
   mig_app_arbiter_if.master             app,
   output logic [$clog2(RD_FIFO_DEPTH):0] rd_outstanding,
   output logic                          rd_underflow
);
   localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(RD_FIFO_DEPTH);

   localparam logic [1:0] WAIT_CAL = 2'd0;
   localparam logic [1:0] ARB      = 2'd1;
   localparam logic [1:0] ISSUE    = 2'd2;

   logic [1:0]                state;
   logic                      last;
   logic                      cur;
   logic [RD_FIFO_DEPTH-1:0]  tag_mem;
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;

   logic                      rd_ok;
   logic                      c0_el;
   logic                      c1_el;
   logic                      win_vld;
   logic                      win;
   logic                      win_wr;
   logic [2:0]                sel_cmd;
   logic [APP_ADDR_WIDTH-1:0] sel_addr;
   logic [APP_DATA_WIDTH-1:0] sel_wdata;
   logic [APP_MASK_WIDTH-1:0] sel_wmask;
   logic                      push;
   logic                      pop;

   // Writes never occupy a tag slot, so only reads are held back by a full FIFO.
   always_comb begin
      rd_ok     = (rd_outstanding < DEPTH);
      c0_el     = c0_req & ((c0_cmd == 3'b000) | rd_ok);
      c1_el     = c1_req & ((c1_cmd == 3'b000) | rd_ok);
      win_vld   = c0_el | c1_el;
      win       = (c0_el & c1_el) ? ~last : c1_el;
      sel_cmd   = win ? c1_cmd   : c0_cmd;
      sel_addr  = win ? c1_addr  : c0_addr;
      sel_wdata = win ? c1_wdata : c0_wdata;
      sel_wmask = win ? c1_wmask : c0_wmask;
      win_wr    = (sel_cmd == 3'b000);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= WAIT_CAL;
         last             <= 1'b1;
         cur              <= 1'b0;
         c0_gnt           <= 1'b0;
         c1_gnt           <= 1'b0;
         app.app_en       <= 1'b0;
         app.app_cmd      <= 3'b000;
         app.app_addr     <= '0;
         app.app_wdf_data <= '0;
         app.app_wdf_mask <= '0;
         app.app_wdf_wren <= 1'b0;
      end else begin
         c0_gnt <= 1'b0;
         c1_gnt <= 1'b0;
         if (app.app_en && app.app_rdy)
            app.app_en <= 1'b0;
         if (app.app_wdf_wren && app.app_wdf_rdy)
            app.app_wdf_wren <= 1'b0;
         case (state)
            WAIT_CAL: if (calib_done) state <= ARB;
            ARB: begin
               if (!calib_done) begin
                  state <= WAIT_CAL;
               end else if (win_vld) begin
                  // Non-write codes are issued to MIG as a plain read.
                  app.app_cmd      <= win_wr ? 3'b000 : 3'b001;
                  app.app_addr     <= sel_addr;
                  app.app_wdf_data <= sel_wdata;
                  app.app_wdf_mask <= sel_wmask;
                  app.app_en       <= 1'b1;
                  app.app_wdf_wren <= win_wr;
                  c0_gnt           <= ~win;
                  c1_gnt           <= win;
                  last             <= win;
                  cur              <= win;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               // Both handshakes are judged on their registered values.
               if (!app.app_en && !app.app_wdf_wren)
                  state <= calib_done ? ARB : WAIT_CAL;
            end
            default: state <= WAIT_CAL;
         endcase
      end
   end

   assign app.app_wdf_end = app.app_wdf_wren;

   assign push = app.app_en & app.app_rdy & (app.app_cmd != 3'b000);
   assign pop  = app.app_rd_data_valid & (rd_outstanding != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_mem        <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         rd_outstanding <= '0;
         rd_underflow   <= 1'b0;
         c0_rvalid      <= 1'b0;
         c1_rvalid      <= 1'b0;
         rdata          <= '0;
      end else begin
         if (push) begin
            tag_mem[wr_ptr] <= cur;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
            2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
            default: rd_outstanding <= rd_outstanding;
         endcase
         // A beat with no tag to pair with is dropped and flagged until reset.
         if (app.app_rd_data_valid && rd_outstanding == '0)
            rd_underflow <= 1'b1;
         c0_rvalid <= pop & ~tag_mem[rd_ptr];
         c1_rvalid <= pop &  tag_mem[rd_ptr];
         if (pop)
            rdata <= app.app_rd_data;
      end
   end
endmodule

// File: tb/tb_mig_app_arbiter.sv
// Bench for mig_app_arbiter: directed scenarios then randomized traffic, all
// checked every cycle against a transaction-level model built on queues.
module tb_mig_app_arbiter;
   localparam int AW = 29;
   localparam int DW = 256;
   localparam int MW = 32;
   localparam int D  = 8;

   logic              clk = 1'b0;
   logic              rst, calib_done;
   logic              c0_req, c1_req;
   logic [2:0]        c0_cmd, c1_cmd;
   logic [AW-1:0]     c0_addr, c1_addr;
   logic [DW-1:0]     c0_wdata, c1_wdata;
   logic [MW-1:0]     c0_wmask, c1_wmask;
   logic              c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
   logic [DW-1:0]     rdata;
   logic [$clog2(D):0] rd_outstanding;
   logic              rd_underflow;

   mig_app_arbiter_if #(.APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW)) app_if ();

   mig_app_arbiter #(
      .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .RD_FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .rst(rst), .calib_done(calib_done),
      .c0_req(c0_req), .c0_cmd(c0_cmd), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_wmask(c0_wmask),
      .c1_req(c1_req), .c1_cmd(c1_cmd), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_wmask(c1_wmask),
      .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
      .rdata(rdata), .app(app_if), .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit auto_cli = 0;
   bit auto_mig = 0;

   // Reference model: phase 0 = waiting for calibration, 1 = free to grant,
   // 2 = a granted request is still handshaking with MIG.
   int            m_ph;
   bit            m_last, m_cur, m_en, m_wren, m_under;
   logic [2:0]    m_cmd;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [MW-1:0] m_wmask;
   bit [1:0]      m_gnt, m_rv;
   int            tagq[$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_last = 1; m_cur = 0; m_en = 0; m_wren = 0; m_under = 0;
      m_cmd = 0; m_addr = 0; m_wdata = 0; m_wmask = 0; m_rdata = 0;
      m_gnt = 0; m_rv = 0;
      tagq.delete();
   endtask

   task automatic model_edge();
      bit en0, wr0, e0, e1;
      int n0, w;
      logic [2:0] cmd;
      if (rst) begin model_reset(); return; end
      en0 = m_en; wr0 = m_wren; n0 = tagq.size();
      m_gnt = 0; m_rv = 0;
      if (app_if.app_rd_data_valid) begin
         if (n0 > 0) begin
            w = tagq.pop_front();
            m_rv[w] = 1;
            m_rdata = app_if.app_rd_data;
         end else m_under = 1;
      end
      if (en0 && app_if.app_rdy && m_cmd != 3'b000) tagq.push_back(int'(m_cur));
      if (en0 && app_if.app_rdy) m_en = 0;
      if (wr0 && app_if.app_wdf_rdy) m_wren = 0;
      case (m_ph)
         0: if (calib_done) m_ph = 1;
         1: if (!calib_done) m_ph = 0;
            else begin
               e0 = c0_req && (c0_cmd == 3'b000 || n0 < D);
               e1 = c1_req && (c1_cmd == 3'b000 || n0 < D);
               if (e0 || e1) begin
                  w = (e0 && e1) ? int'(!m_last) : (e1 ? 1 : 0);
                  cmd     = w ? c1_cmd : c0_cmd;
                  m_addr  = w ? c1_addr : c0_addr;
                  m_wdata = w ? c1_wdata : c0_wdata;
                  m_wmask = w ? c1_wmask : c0_wmask;
                  m_cmd   = (cmd == 3'b000) ? 3'b000 : 3'b001;
                  m_en    = 1;
                  m_wren  = (cmd == 3'b000);
                  m_gnt[w] = 1;
                  m_last  = (w == 1);
                  m_cur   = (w == 1);
                  m_ph    = 2;
               end
            end
         default: if (!en0 && !wr0) m_ph = calib_done ? 1 : 0;
      endcase
   endtask

   task automatic compare_all();
      chk("c0_gnt",         DW'(c0_gnt),              DW'(m_gnt[0]));
      chk("c1_gnt",         DW'(c1_gnt),              DW'(m_gnt[1]));
      chk("app_en",         DW'(app_if.app_en),       DW'(m_en));
      chk("app_cmd",        DW'(app_if.app_cmd),      DW'(m_cmd));
      chk("app_addr",       DW'(app_if.app_addr),     DW'(m_addr));
      chk("app_wdf_data",   app_if.app_wdf_data,      m_wdata);
      chk("app_wdf_mask",   DW'(app_if.app_wdf_mask), DW'(m_wmask));
      chk("app_wdf_wren",   DW'(app_if.app_wdf_wren), DW'(m_wren));
      chk("app_wdf_end",    DW'(app_if.app_wdf_end),  DW'(m_wren));
      chk("c0_rvalid",      DW'(c0_rvalid),           DW'(m_rv[0]));
      chk("c1_rvalid",      DW'(c1_rvalid),           DW'(m_rv[1]));
      chk("rdata",          rdata,                    m_rdata);
      chk("rd_outstanding", DW'(rd_outstanding),      DW'(tagq.size()));
      chk("rd_underflow",   DW'(rd_underflow),        DW'(m_under));
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic new_req(input int who);
      logic [2:0] cmd;
      int r;
      r = int'($urandom_range(0, 9));
      cmd = (r < 4) ? 3'b000 : (r < 8) ? 3'b001 : 3'($urandom_range(2, 7));
      if (who == 0) begin
         c0_req = 1; c0_cmd = cmd; c0_addr = AW'($urandom); c0_wdata = rnd_data(); c0_wmask = MW'($urandom);
      end else begin
         c1_req = 1; c1_cmd = cmd; c1_addr = AW'($urandom); c1_wdata = rnd_data(); c1_wmask = MW'($urandom);
      end
   endtask

   task automatic step();
      if (auto_cli) begin
         if (c0_gnt) c0_req = 0;
         if (c1_gnt) c1_req = 0;
         if (!c0_req && $urandom_range(0, 2) == 0) new_req(0);
         if (!c1_req && $urandom_range(0, 2) == 0) new_req(1);
      end
      if (auto_mig) begin
         app_if.app_rdy     = ($urandom_range(0, 3) != 0);
         app_if.app_wdf_rdy = ($urandom_range(0, 2) != 0);
         app_if.app_rd_data_valid = (tagq.size() > 0 && $urandom_range(0, 2) == 0);
         app_if.app_rd_data = rnd_data();
         if (calib_done && $urandom_range(0, 299) == 0) calib_done = 0;
         else if (!calib_done && $urandom_range(0, 5) == 0) calib_done = 1;
      end
      model_edge();
      @(posedge clk); #1;
      compare_all();
      cyc++;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ng, cnt;
      int gw[4];
      int gc[4];
      bit found;
      logic [DW-1:0] pat;

      rst = 1; calib_done = 0;
      c0_req = 0; c0_cmd = 0; c0_addr = 0; c0_wdata = 0; c0_wmask = 0;
      c1_req = 0; c1_cmd = 0; c1_addr = 0; c1_wdata = 0; c1_wmask = 0;
      app_if.app_rdy = 0; app_if.app_wdf_rdy = 0;
      app_if.app_rd_data = 0; app_if.app_rd_data_valid = 0;
      model_reset();
      step(); step();
      chk("rst_app_en", DW'(app_if.app_en), DW'(0));
      chk("rst_c0_gnt", DW'(c0_gnt), DW'(0));
      chk("rst_outstanding", DW'(rd_outstanding), DW'(0));
      rst = 0;

      // Scenario 1: no grant before calibration; grant two cycles after it
      c0_req = 1; c0_cmd = 3'b000; c0_addr = 29'h0ABC_DE0;
      c0_wdata = {8{32'h1234_5678}}; c0_wmask = 32'h0000_00FF;
      repeat (4) begin
         step();
         chk("s1_nogrant", DW'(c0_gnt), DW'(0));
         chk("s1_noen", DW'(app_if.app_en), DW'(0));
      end
      calib_done = 1;
      step();
      chk("s1_gnt_early", DW'(c0_gnt), DW'(0));
      step();
      chk("s1_gnt", DW'(c0_gnt), DW'(1));
      chk("s1_en", DW'(app_if.app_en), DW'(1));
      chk("s1_cmd", DW'(app_if.app_cmd), DW'(0));
      chk("s1_wren", DW'(app_if.app_wdf_wren), DW'(1));
      chk("s1_end", DW'(app_if.app_wdf_end), DW'(1));
      chk("s1_addr", DW'(app_if.app_addr), DW'(29'h0ABC_DE0));
      c0_req = 0; app_if.app_rdy = 1; app_if.app_wdf_rdy = 1;
      step();
      chk("s1_done", DW'({app_if.app_en, app_if.app_wdf_wren}), DW'(0));
      step();

      // Scenario 2: two continuous readers alternate at 3-cycle spacing
      rst = 1; step(); rst = 0;
      c0_req = 1; c0_cmd = 3'b001; c0_addr = 29'h100;
      c1_req = 1; c1_cmd = 3'b001; c1_addr = 29'h200;
      ng = 0;
      for (int k = 0; k < 4; k++) begin gw[k] = -1; gc[k] = 0; end
      for (int i = 0; i < 40 && ng < 4; i++) begin
         step();
         if (c0_gnt || c1_gnt) begin
            gw[ng] = c1_gnt ? 1 : 0; gc[ng] = cyc; ng++;
            if (ng == 4) begin c0_req = 0; c1_req = 0; end
         end
      end
      chk("s2_grants", DW'(ng), DW'(4));
      for (int k = 0; k < 4; k++) chk("s2_order", DW'(gw[k]), DW'(k % 2));
      for (int k = 1; k < 4; k++) chk("s2_spacing", DW'(gc[k] - gc[k-1]), DW'(3));
      step(); step();
      chk("s2_outstanding", DW'(rd_outstanding), DW'(4));
      for (int k = 0; k < 4; k++) begin
         pat = {8{32'hCAFE_BABE}};
         pat[31:0] = 32'hCAFE_BABE + 32'(k);
         app_if.app_rd_data = pat; app_if.app_rd_data_valid = 1;
         step();
         chk("s2_rv_c0", DW'(c0_rvalid), DW'(k % 2 == 0));
         chk("s2_rv_c1", DW'(c1_rvalid), DW'(k % 2 == 1));
         chk("s2_rdata", rdata, pat);
      end
      app_if.app_rd_data_valid = 0;
      step();

      // Scenario 3: command accepted at once, write data stalled for 5 cycles
      app_if.app_rdy = 1; app_if.app_wdf_rdy = 0;
      c0_req = 1; c0_cmd = 3'b000; c0_addr = 29'h300; c0_wdata = rnd_data(); c0_wmask = 32'hF0F0_0000;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         found = c0_gnt;
      end
      chk("s3_gnt", DW'(found), DW'(1));
      c0_req = 0;
      c1_req = 1; c1_cmd = 3'b000; c1_addr = 29'h400; c1_wdata = rnd_data(); c1_wmask = 0;
      chk("s3_en0", DW'(app_if.app_en), DW'(1));
      chk("s3_wren0", DW'(app_if.app_wdf_wren), DW'(1));
      step();
      chk("s3_en_drop", DW'(app_if.app_en), DW'(0));
      for (int i = 0; i < 4; i++) begin
         chk("s3_wren_hold", DW'(app_if.app_wdf_wren), DW'(1));
         chk("s3_no_gnt", DW'(c1_gnt), DW'(0));
         if (i < 3) step();
      end
      app_if.app_wdf_rdy = 1;
      step();
      chk("s3_wren_drop", DW'(app_if.app_wdf_wren), DW'(0));
      step();
      chk("s3_no_gnt_detect", DW'(c1_gnt), DW'(0));
      step();
      chk("s3_next_gnt", DW'(c1_gnt), DW'(1));
      c1_req = 0;
      repeat (3) step();

      // Scenario 4: full tag FIFO blocks reads but not writes
      rst = 1; step(); rst = 0;
      c0_req = 1; c0_cmd = 3'b001; c0_addr = 29'h500;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (c0_gnt) cnt++;
      end
      chk("s4_read_grants", DW'(cnt), DW'(8));
      chk("s4_full", DW'(rd_outstanding), DW'(8));
      c1_req = 1; c1_cmd = 3'b000; c1_addr = 29'h600; c1_wdata = rnd_data();
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         found = c1_gnt;
      end
      chk("s4_write_gnt", DW'(found), DW'(1));
      c1_req = 0;
      repeat (6) begin
         step();
         chk("s4_read_blocked", DW'(c0_gnt), DW'(0));
      end
      app_if.app_rd_data = {8{32'h0BAD_F00D}}; app_if.app_rd_data_valid = 1;
      step();
      chk("s4_rv", DW'(c0_rvalid), DW'(1));
      chk("s4_after_pop", DW'(rd_outstanding), DW'(7));
      app_if.app_rd_data_valid = 0;
      step();
      chk("s4_unblocked", DW'(c0_gnt), DW'(1));

      // Scenario 5: simultaneous push/pop, then underflow
      c0_req = 0; app_if.app_rdy = 0;
      step();
      chk("s5_pending", DW'(app_if.app_en), DW'(1));
      app_if.app_rdy = 1; app_if.app_rd_data_valid = 1; app_if.app_rd_data = {8{32'h5A5A_A5A5}};
      step();
      chk("s5_pushpop", DW'(rd_outstanding), DW'(7));
      chk("s5_pushpop_rv", DW'(c0_rvalid), DW'(1));
      for (int i = 0; i < 7; i++) begin
         app_if.app_rd_data = rnd_data();
         step();
         chk("s5_drain_rv", DW'(c0_rvalid), DW'(1));
      end
      chk("s5_empty", DW'(rd_outstanding), DW'(0));
      chk("s5_no_under", DW'(rd_underflow), DW'(0));
      step();
      chk("s5_under_rv", DW'({c1_rvalid, c0_rvalid}), DW'(0));
      chk("s5_under", DW'(rd_underflow), DW'(1));
      app_if.app_rd_data_valid = 0;
      repeat (3) step();
      chk("s5_sticky", DW'(rd_underflow), DW'(1));

      // Scenario 6: async reset mid-ISSUE with reads outstanding
      rst = 1; step(); rst = 0;
      chk("s6_under_clr", DW'(rd_underflow), DW'(0));
      c1_req = 1; c1_cmd = 3'b001; c1_addr = 29'h700;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         found = (rd_outstanding == 3);
      end
      chk("s6_three", DW'(found), DW'(1));
      app_if.app_rdy = 0;
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         step();
         found = c1_gnt;
      end
      c1_req = 0;
      step(); step();
      chk("s6_stalled", DW'(app_if.app_en), DW'(1));
      rst = 1;
      #2;
      chk("s6_rst_en", DW'(app_if.app_en), DW'(0));
      chk("s6_rst_cmd", DW'(app_if.app_cmd), DW'(0));
      chk("s6_rst_addr", DW'(app_if.app_addr), DW'(0));
      chk("s6_rst_wren", DW'(app_if.app_wdf_wren), DW'(0));
      chk("s6_rst_out", DW'(rd_outstanding), DW'(0));
      chk("s6_rst_gnt", DW'({c1_gnt, c0_gnt}), DW'(0));
      model_reset();
      step();
      rst = 0;
      app_if.app_rd_data_valid = 1;
      step();
      chk("s6_late_under", DW'(rd_underflow), DW'(1));
      chk("s6_late_rv", DW'({c1_rvalid, c0_rvalid}), DW'(0));
      app_if.app_rd_data_valid = 0;

      // Randomized traffic
      rst = 1; step(); rst = 0;
      auto_cli = 1; auto_mig = 1;
      repeat (3000) step();
      auto_cli = 0; auto_mig = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
